instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_fetch_unit_pc_register.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: datapath width, NOP encoding,
// fetch FSM states and the branch-taken decision used by the PC register.
package proc_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    // BEQ takes on zero, BNE on non-zero; an unconditional write always takes.
    function automatic logic branch_taken(input logic pc_write,
                                          input logic pc_write_cond,
                                          input logic alu_zero,
                                          input logic branch_op);
        return pc_write | (pc_write_cond & (alu_zero ^ branch_op));
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(parameter int XLEN = proc_pkg::XLEN) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);

endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter with the unconditional / conditional-branch update mux.
module pc_register
    import proc_pkg::*;
#(
    parameter int              XLEN     = proc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            pc_src,
    input  logic            branch_op,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] next_pc_s;
    logic            taken_s;

    // Branch decision and target selection.
    always_comb begin
        taken_s = branch_taken(pc_write, pc_write_cond, alu_zero, branch_op);
        if (pc_src) begin
            next_pc_s = alu_out;
        end else begin
            next_pc_s = alu_result;
        end
    end

    // PC register, updated whenever the control unit's strobes say so.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (taken_s) begin
            pc_r <= next_pc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, drives a variable-latency instruction memory
// over req/ack, and latches a sticky fault on misaligned fetch or timeout.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int              XLEN     = proc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_ir,
    input  logic                pc_write,
    input  logic                pc_write_cond,
    input  logic                pc_src,
    input  logic                branch_op,
    input  logic                alu_zero,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     alu_out,
    instr_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]     pc,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic                busy,
    output logic                fault
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [XLEN-1:0]  addr_r, addr_s;
    logic [31:0]      instr_r, instr_s;
    logic             valid_r, valid_s;
    logic             fault_r, fault_s;
    logic             req_r, req_s;
    logic             aligned_s;

    pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_register (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .branch_op     (branch_op),
        .alu_zero      (alu_zero),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .pc            (pc)
    );

    assign aligned_s = (pc[1:0] == 2'b00);

    // Fetch FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {XLEN{1'b0}};
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            instr_r <= instr_s;
            valid_r <= valid_s;
            fault_r <= fault_s;
            req_r   <= req_s;
        end
    end

    // Next-state decision; undecodable states fall into the safe ERR state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_ir) begin
                    if (aligned_s) begin
                        state_s = REQ;
                    end else begin
                        state_s = ERR;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ERR;
                end else begin
                    state_s = REQ;
                end
            end
            ERR:     state_s = ERR;
            default: state_s = ERR;
        endcase
    end

    // Next values of the registered outputs, IR and timeout counter.
    always_comb begin
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        instr_s = instr_r;
        valid_s = valid_r;
        fault_s = fault_r;
        case (state_r)
            IDLE: begin
                if (load_ir) begin
                    valid_s = 1'b0;
                    if (aligned_s) begin
                        addr_s = pc;
                        cnt_s  = {CNT_W{1'b0}};
                    end else begin
                        fault_s = 1'b1;
                    end
                end else begin
                    valid_s = valid_r;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    instr_s = imem.imem_rdata;
                    valid_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    fault_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ERR: valid_s = 1'b0;
            default: begin
                valid_s = 1'b0;
                fault_s = 1'b1;
            end
        endcase
        req_s = (state_s == REQ);
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign busy           = req_r;
    assign instruction    = instr_r;
    assign instr_valid    = valid_r;
    assign fault          = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: one record per clock cycle,
// inputs applied before the edge and outputs compared 1 time unit after it.
module tb_instr_fetch_unit;
    import proc_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        rst, load_ir, pc_write, pc_write_cond, pc_src, branch_op, alu_zero, ack;
        logic [63:0] alu_result, alu_out;
        logic [31:0] rdata;
        logic [63:0] e_pc, e_addr;
        logic [31:0] e_instr;
        logic        e_valid, e_req, e_fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, load_ir, pc_write, pc_write_cond, pc_src, branch_op, alu_zero;
    logic [63:0] alu_result, alu_out, pc;
    logic [31:0] instruction;
    logic        instr_valid, busy, fault;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(64)) imem ();

    instr_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_ir       (load_ir),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .branch_op     (branch_op),
        .alu_zero      (alu_zero),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .imem          (imem),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .fault         (fault)
    );

    function automatic vec_t mkv(input logic r, input logic ld, input logic pw, input logic pwc,
                                 input logic src, input logic bo, input logic az, input logic ack,
                                 input logic [63:0] ares, input logic [63:0] aout, input logic [31:0] rd,
                                 input logic [63:0] epc, input logic [63:0] eaddr, input logic [31:0] einstr,
                                 input logic ev, input logic ereq, input logic ef);
        vec_t v;
        v.rst = r; v.load_ir = ld; v.pc_write = pw; v.pc_write_cond = pwc;
        v.pc_src = src; v.branch_op = bo; v.alu_zero = az; v.ack = ack;
        v.alu_result = ares; v.alu_out = aout; v.rdata = rd;
        v.e_pc = epc; v.e_addr = eaddr; v.e_instr = einstr;
        v.e_valid = ev; v.e_req = ereq; v.e_fault = ef;
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        rst = v.rst; load_ir = v.load_ir; pc_write = v.pc_write; pc_write_cond = v.pc_write_cond;
        pc_src = v.pc_src; branch_op = v.branch_op; alu_zero = v.alu_zero;
        alu_result = v.alu_result; alu_out = v.alu_out;
        imem.imem_ack = v.ack; imem.imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        n_vec++;
        if (pc !== v.e_pc) begin
            n_err++; $display("FAIL %s pc: got %h expected %h", tag, pc, v.e_pc);
        end
        if (imem.imem_addr !== v.e_addr) begin
            n_err++; $display("FAIL %s imem_addr: got %h expected %h", tag, imem.imem_addr, v.e_addr);
        end
        if (instruction !== v.e_instr) begin
            n_err++; $display("FAIL %s instruction: got %h expected %h", tag, instruction, v.e_instr);
        end
        if (instr_valid !== v.e_valid) begin
            n_err++; $display("FAIL %s instr_valid: got %b expected %b", tag, instr_valid, v.e_valid);
        end
        if (imem.imem_req !== v.e_req) begin
            n_err++; $display("FAIL %s imem_req: got %b expected %b", tag, imem.imem_req, v.e_req);
        end
        if (busy !== v.e_req) begin
            n_err++; $display("FAIL %s busy: got %b expected %b", tag, busy, v.e_req);
        end
        if (fault !== v.e_fault) begin
            n_err++; $display("FAIL %s fault: got %b expected %b", tag, fault, v.e_fault);
        end
    endtask

    vec_t tbl[15];

    initial begin
        //            r  ld pw pwc s  bo az ack ares     aout     rdata          pc       addr     instr          v  req f
        tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 64'h0,   64'h0,   32'h0,         64'h0,   64'h0,   NOP_INSTR,     0, 0, 0);
        tbl[1]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0,   64'h0,   32'h0,         64'h0,   64'h0,   NOP_INSTR,     0, 1, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,   64'h0,   32'h0000_0533, 64'h0,   64'h0,   32'h0000_0533, 1, 0, 0);
        tbl[3]  = mkv(0, 1, 1, 0, 0, 0, 0, 0, 64'h4,   64'h0,   32'h0,         64'h4,   64'h0,   32'h0000_0533, 0, 1, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,   64'h0,   32'h00a0_0093, 64'h4,   64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[5]  = mkv(0, 0, 0, 1, 1, 0, 1, 0, 64'h99,  64'h40,  32'h0,         64'h40,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 1, 1, 0, 0, 0, 64'h99,  64'h80,  32'h0,         64'h40,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[7]  = mkv(0, 0, 0, 1, 1, 1, 0, 0, 64'h99,  64'h80,  32'h0,         64'h80,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[8]  = mkv(0, 0, 0, 1, 1, 1, 1, 0, 64'h99,  64'h100, 32'h0,         64'h80,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[9]  = mkv(0, 0, 1, 1, 0, 0, 0, 0, 64'h84,  64'h200, 32'h0,         64'h84,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,   64'h0,   32'hdead_beef, 64'h84,  64'h0,   32'h00a0_0093, 1, 0, 0);
        tbl[11] = mkv(0, 1, 1, 0, 1, 0, 0, 0, 64'h0,   64'h90,  32'h0,         64'h90,  64'h84,  32'h00a0_0093, 0, 1, 0);
        tbl[12] = mkv(0, 0, 1, 0, 0, 0, 0, 0, 64'h94,  64'h0,   32'h0,         64'h94,  64'h84,  32'h00a0_0093, 0, 1, 0);
        tbl[13] = mkv(0, 1, 0, 0, 0, 0, 0, 1, 64'h0,   64'h0,   32'h1234_5678, 64'h94,  64'h84,  32'h1234_5678, 1, 0, 0);
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,   64'h0,   32'h0,         64'h94,  64'h84,  32'h1234_5678, 1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // 5-cycle memory; load_ir held high during REQ must not start a second fetch.
        apply("lat5_start", mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'h1234_5678, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("lat5_wait%0d", i),
                  mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'h1234_5678, 0, 1, 0));
        end
        apply("lat5_ack",  mkv(0, 1, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 32'hcafe_0137, 64'h94, 64'h94, 32'hcafe_0137, 1, 0, 0));
        apply("lat5_idle", mkv(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'hcafe_0137, 1, 0, 0));

        // Timeout: fault exactly at the end of the TIMEOUT-th request cycle.
        apply("to_start", mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'hcafe_0137, 0, 1, 0));
        for (int i = 1; i < TIMEOUT; i++) begin
            apply($sformatf("to_wait%0d", i),
                  mkv(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'hcafe_0137, 0, 1, 0));
        end
        apply("to_fault", mkv(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 32'h0, 64'h94, 64'h94, 32'hcafe_0137, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            apply($sformatf("err_ignore%0d", i),
                  mkv(0, 1, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 32'h0000_0055, 64'h94, 64'h94, 32'hcafe_0137, 0, 0, 1));
        end

        // Misaligned fetch, then reset in the middle of a request with a late ack.
        apply("rst1",     mkv(1, 0, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0, 32'h0, 64'h0,  64'h0, NOP_INSTR, 0, 0, 0));
        apply("pc_42",    mkv(0, 0, 1, 0, 0, 0, 0, 0, 64'h42, 64'h0, 32'h0, 64'h42, 64'h0, NOP_INSTR, 0, 0, 0));
        apply("mis_load", mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0, 32'h0, 64'h42, 64'h0, NOP_INSTR, 0, 0, 1));
        apply("mis_hold", mkv(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,  64'h0, 32'h0, 64'h42, 64'h0, NOP_INSTR, 0, 0, 1));
        apply("rst2",     mkv(1, 0, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0, 32'h0, 64'h0,  64'h0, NOP_INSTR, 0, 0, 0));
        apply("pc_8",     mkv(0, 0, 1, 0, 0, 0, 0, 0, 64'h8,  64'h0, 32'h0, 64'h8,  64'h0, NOP_INSTR, 0, 0, 0));
        apply("req_8",    mkv(0, 1, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0, 32'h0, 64'h8,  64'h8, NOP_INSTR, 0, 1, 0));
        apply("req_8w",   mkv(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,  64'h0, 32'h0, 64'h8,  64'h8, NOP_INSTR, 0, 1, 0));
        apply("rst_mid",  mkv(1, 0, 0, 0, 0, 0, 0, 1, 64'h0,  64'h0, 32'h0000_0077, 64'h0, 64'h0, NOP_INSTR, 0, 0, 0));
        apply("late_ack", mkv(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,  64'h0, 32'h0000_0077, 64'h0, 64'h0, NOP_INSTR, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
